// File: rtl/svm_sequencer_if.sv
// Handshake and control bus between the SVM sequencer and its datapath/memories.
// The sequencer drives the bus through the master modport.
interface svm_sequencer_if #(
   parameter int SV_AW = 18,
   parameter int A_AW  = 14,
   parameter int F_W   = 4
);
   logic             start;
   logic             abort;
   logic             dp_ready;
   logic             busy;
   logic             mem_en;
   logic [SV_AW-1:0] sv_addr;
   logic [A_AW-1:0]  alpha_addr;
   logic [F_W-1:0]   feat_idx;
   logic             acc_clear;
   logic             feat_valid;
   logic             feat_last;
   logic             sv_last;
   logic             done;

   modport master (
      input  start, abort, dp_ready,
      output busy, mem_en, sv_addr, alpha_addr, feat_idx,
             acc_clear, feat_valid, feat_last, sv_last, done
   );

   modport slave (
      output start, abort, dp_ready,
      input  busy, mem_en, sv_addr, alpha_addr, feat_idx,
             acc_clear, feat_valid, feat_last, sv_last, done
   );
endinterface

// File: rtl/svm_sequencer.sv
// SVM classification sequencer: walks all support vectors and features, issues
// memory reads and returns latency-aligned control strobes to the datapath.
module svm_sequencer #(
   parameter int NUM_SV       = 11237,
   parameter int FEATURE_SIZE = 13,
   parameter int READ_LATENCY = 1,
   parameter int SV_AW        = 18,
   parameter int A_AW         = 14,
   parameter int F_W          = 4
) (
   input logic              clk,
   input logic              rst,
   svm_sequencer_if.master  bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int              TAIL     = READ_LATENCY - 1;
   localparam logic [F_W-1:0]  FEAT_MAX = F_W'(FEATURE_SIZE - 1);
   localparam logic [A_AW-1:0] SV_MAX   = A_AW'(NUM_SV - 1);

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [F_W-1:0]   feat_cnt;
   logic [A_AW-1:0]  sv_cnt;
   logic [SV_AW-1:0] addr_cnt;
   logic             issue;
   logic             kill;
   logic             cnt_feat_last;
   logic             cnt_sv_last;

   logic [READ_LATENCY-1:0] pipe_v;
   logic [READ_LATENCY-1:0] pipe_fl;
   logic [READ_LATENCY-1:0] pipe_sl;
   logic [F_W-1:0]          pipe_f [READ_LATENCY];

   assign kill          = bus.abort && (state == S_CLEAR || state == S_ISSUE || state == S_DRAIN);
   assign issue         = (state == S_ISSUE) && bus.dp_ready && !bus.abort;
   assign cnt_feat_last = (feat_cnt == FEAT_MAX);
   assign cnt_sv_last   = cnt_feat_last && (sv_cnt == SV_MAX);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start && !bus.abort) state_nxt = S_CLEAR;
         S_CLEAR: state_nxt = S_ISSUE;
         S_ISSUE: if (issue && cnt_sv_last) state_nxt = S_DRAIN;
         S_DRAIN: if (pipe_v[TAIL] && pipe_sl[TAIL]) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (kill) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Linear address runs as its own +1 counter; the final issue holds all counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         feat_cnt <= '0;
         sv_cnt   <= '0;
         addr_cnt <= '0;
      end else if (state == S_CLEAR) begin
         feat_cnt <= '0;
         sv_cnt   <= '0;
         addr_cnt <= '0;
      end else if (issue && !cnt_sv_last) begin
         addr_cnt <= addr_cnt + 1'b1;
         if (cnt_feat_last) begin
            feat_cnt <= '0;
            sv_cnt   <= sv_cnt + 1'b1;
         end else begin
            feat_cnt <= feat_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_v  <= '0;
         pipe_fl <= '0;
         pipe_sl <= '0;
         for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_f[i] <= '0;
      end else if (kill) begin
         pipe_v  <= '0;
         pipe_fl <= '0;
         pipe_sl <= '0;
         for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_f[i] <= '0;
      end else begin
         pipe_v[0]  <= issue;
         pipe_fl[0] <= issue && cnt_feat_last;
         pipe_sl[0] <= issue && cnt_sv_last;
         pipe_f[0]  <= feat_cnt;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_v[i]  <= pipe_v[i-1];
            pipe_fl[i] <= pipe_fl[i-1];
            pipe_sl[i] <= pipe_sl[i-1];
            pipe_f[i]  <= pipe_f[i-1];
         end
      end
   end

   assign bus.busy       = (state != S_IDLE);
   assign bus.mem_en     = issue;
   assign bus.sv_addr    = addr_cnt;
   assign bus.alpha_addr = sv_cnt;
   assign bus.feat_idx   = pipe_f[TAIL];
   assign bus.acc_clear  = (state == S_CLEAR);
   assign bus.feat_valid = pipe_v[TAIL];
   assign bus.feat_last  = pipe_fl[TAIL];
   assign bus.sv_last    = pipe_sl[TAIL];
   assign bus.done       = (state == S_DONE);

endmodule

// File: tb/tb_svm_sequencer.sv
// Directed bench for svm_sequencer: a negedge monitor builds an issue-side
// scoreboard and event log; the main sequence checks them after each scenario.
module tb_svm_sequencer;
   localparam int NSV = 3, FS = 4, RL = 2;
   localparam int NSV_B = 5, FS_B = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   svm_sequencer_if #(.SV_AW(4), .A_AW(2), .F_W(2)) ifa ();
   svm_sequencer_if #(.SV_AW(4), .A_AW(3), .F_W(2)) ifb ();

   svm_sequencer #(.NUM_SV(NSV), .FEATURE_SIZE(FS), .READ_LATENCY(RL),
                   .SV_AW(4), .A_AW(2), .F_W(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   svm_sequencer #(.NUM_SV(NSV_B), .FEATURE_SIZE(FS_B), .READ_LATENCY(1),
                   .SV_AW(4), .A_AW(3), .F_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   logic [31:0] outs_a, outs_b;
   assign outs_a = 32'({ifa.busy, ifa.mem_en, ifa.acc_clear, ifa.feat_valid, ifa.feat_last,
                        ifa.sv_last, ifa.done, ifa.sv_addr, ifa.alpha_addr, ifa.feat_idx});
   assign outs_b = 32'({ifb.busy, ifb.mem_en, ifb.acc_clear, ifb.feat_valid, ifb.feat_last,
                        ifb.sv_last, ifb.done, ifb.sv_addr, ifb.alpha_addr, ifb.feat_idx});

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Monitor-owned state; the main sequence only reads it.
   typedef struct { int f; bit fl; bit sl; int cyc; } beat_t;
   typedef struct { string tag; logic [31:0] obs; logic [31:0] exp; } cmp_t;
   beat_t sbq[$];
   cmp_t  cmpq[$];
   int rel = 0, e_addr = 0, clr_seen = 0;
   int first_clr, last_clr, n_clr, first_mem, last_mem, n_mem;
   int first_fv, last_fv, n_fv, first_busy, last_busy, first_done, last_done, n_done;
   int clr_req = 0;
   int rd = 0;

   function automatic void put(input string t, input logic [31:0] o, input logic [31:0] e);
      cmpq.push_back('{t, o, e});
   endfunction

   always @(negedge clk) begin
      beat_t b;
      if (clr_req != clr_seen) begin
         clr_seen = clr_req;
         rel = 1;
         sbq.delete();
         first_clr = -1; last_clr = -1; n_clr = 0; first_mem = -1; last_mem = -1; n_mem = 0;
         first_fv = -1; last_fv = -1; n_fv = 0; first_busy = -1; last_busy = -1;
         first_done = -1; last_done = -1; n_done = 0;
      end else begin
         rel++;
      end
      if (ifa.acc_clear) begin
         if (n_clr == 0) first_clr = rel;
         last_clr = rel; n_clr++; e_addr = 0;
      end
      if (ifa.busy) begin
         if (first_busy < 0) first_busy = rel;
         last_busy = rel;
      end
      if (ifa.mem_en) begin
         if (first_mem < 0) first_mem = rel;
         last_mem = rel; n_mem++;
         put("sv_addr", 32'(ifa.sv_addr), e_addr);
         put("alpha_addr", 32'(ifa.alpha_addr), e_addr / FS);
         sbq.push_back('{e_addr % FS, (e_addr % FS) == FS - 1, e_addr == NSV * FS - 1, rel});
         e_addr++;
      end
      if (ifa.feat_valid) begin
         if (first_fv < 0) first_fv = rel;
         last_fv = rel; n_fv++;
         put("sb_has_entry", 32'(sbq.size() > 0), 1);
         if (sbq.size() > 0) begin
            b = sbq.pop_front();
            put("feat_idx", 32'(ifa.feat_idx), b.f);
            put("feat_last", 32'(ifa.feat_last), 32'(b.fl));
            put("sv_last", 32'(ifa.sv_last), 32'(b.sl));
            put("fv_latency", rel - b.cyc, RL);
         end
      end
      if (ifa.done) begin
         if (n_done == 0) first_done = rel;
         last_done = rel; n_done++;
      end
   end

   task automatic drain();
      while (rd < cmpq.size()) begin
         chk(cmpq[rd].tag, cmpq[rd].obs, cmpq[rd].exp);
         rd++;
      end
   endtask

   task automatic kick();
      @(negedge clk); #1;
      clr_req++;
      ifa.start = 1'b1;
      @(posedge clk); #1;
      ifa.start = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget);
      int i = 0;
      while (n_done < n && i < budget) begin
         @(posedge clk);
         i++;
      end
      chk("done_within_budget", 32'(n_done >= n), 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int nm, lsv, lal, slc, dc;
      ifa.start = 0; ifa.abort = 0; ifa.dp_ready = 1;
      ifb.start = 0; ifb.abort = 0; ifb.dp_ready = 1;
      #1;
      chk("reset_outputs_a", outs_a, 0);
      chk("reset_outputs_b", outs_b, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Uninterrupted run
      kick();
      wait_done(1, 60);
      chk("t1_clear_cycle", first_clr, 1);
      chk("t1_clear_count", n_clr, 1);
      chk("t1_first_mem", first_mem, 2);
      chk("t1_last_mem", last_mem, 13);
      chk("t1_issues", n_mem, 12);
      chk("t1_first_fv", first_fv, 4);
      chk("t1_last_fv", last_fv, 15);
      chk("t1_done_cycle", first_done, 16);
      chk("t1_done_count", n_done, 1);
      chk("t1_busy_first", first_busy, 1);
      chk("t1_busy_last", last_busy, 16);
      chk("t1_sb_empty", sbq.size(), 0);
      drain();

      // dp_ready low in cycles 5..7
      kick();
      repeat (4) @(posedge clk);
      #1 ifa.dp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #2;
         chk("t2_stall_addr", 32'(ifa.sv_addr), 3);
         chk("t2_stall_mem_en", 32'(ifa.mem_en), 0);
         @(posedge clk); #1;
      end
      ifa.dp_ready = 1'b1;
      wait_done(1, 60);
      chk("t2_issues", n_mem, 12);
      chk("t2_last_mem", last_mem, 16);
      chk("t2_last_fv", last_fv, 18);
      chk("t2_done_cycle", first_done, 19);
      chk("t2_sb_empty", sbq.size(), 0);
      drain();

      // abort during cycle 8, then a clean rerun
      kick();
      repeat (7) @(posedge clk);
      #1 ifa.abort = 1'b1;
      @(posedge clk);
      #1 ifa.abort = 1'b0;
      chk("t3_busy_after_abort", 32'(ifa.busy), 0);
      chk("t3_fv_after_abort", 32'(ifa.feat_valid), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("t3_no_done", n_done, 0);
      chk("t3_last_fv", last_fv, 8);
      chk("t3_last_busy", last_busy, 8);
      drain();
      kick();
      wait_done(1, 60);
      chk("t3_rerun_issues", n_mem, 12);
      chk("t3_rerun_done", first_done, 16);
      drain();

      // asynchronous reset mid-ISSUE
      kick();
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t4_async_reset_outputs", outs_a, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t4_idle_busy", 32'(ifa.busy), 0);
      chk("t4_no_done", n_done, 0);
      drain();

      // start held high across edges 0..19
      @(negedge clk); #1;
      clr_req++;
      ifa.start = 1'b1;
      repeat (20) @(posedge clk);
      #1 ifa.start = 1'b0;
      wait_done(2, 60);
      chk("t5_first_done", first_done, 16);
      chk("t5_clear_count", n_clr, 2);
      chk("t5_first_clear", first_clr, 1);
      chk("t5_second_clear", last_clr, 18);
      chk("t5_second_done", last_done, 33);
      chk("t5_done_count", n_done, 2);
      drain();

      // READ_LATENCY=1 instance, 5 SVs x 3 features
      @(negedge clk); #1 ifb.start = 1'b1;
      @(posedge clk); #1 ifb.start = 1'b0;
      nm = 0; lsv = -1; lal = -1; slc = -1; dc = -1;
      for (int c = 1; c <= 25; c++) begin
         if (ifb.mem_en) begin
            nm++;
            lsv = int'(ifb.sv_addr);
            lal = int'(ifb.alpha_addr);
         end
         if (ifb.feat_valid && ifb.sv_last) slc = c;
         if (ifb.done && dc < 0) dc = c;
         @(posedge clk); #1;
      end
      chk("b_issues", nm, NSV_B * FS_B);
      chk("b_last_sv_addr", lsv, NSV_B * FS_B - 1);
      chk("b_last_alpha_addr", lal, NSV_B - 1);
      chk("b_sv_last_cycle", slc, 1 + NSV_B * FS_B + 1);
      chk("b_done_cycle", dc, 2 + NSV_B * FS_B + 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
